// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 slave receiver, fully oversampled in the clk domain.
//   Pins sclk/mosi/ss pass through equal-depth synchronizers, sclk/ss edges are
//   detected on the synced copies, and DATA_WIDTH-bit words are rebuilt and
//   handed out on a valid/ready port backed by a single holding register.
// Ports:
//   clk, rst          system clock, async active-high reset
//   sclk, mosi, ss    SPI pins from the master (async to clk, ss active-low)
//   rx_data/rx_valid  received word and its valid flag (held until accepted)
//   rx_ready          consumer accept
//   overrun           1-cycle pulse: word completed while holding reg full
//   frame_err         1-cycle pulse: ss deasserted mid-word
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 12,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  overrun,
  output logic                  frame_err
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
  logic                   r_sclk_d, r_ss_d;
  state_t                 r_state, w_state_nx;
  logic [CW-1:0]          r_bit_cnt, w_cnt_nx;
  logic [DATA_WIDTH-1:0]  r_shift, w_shift_nx;
  logic [DATA_WIDTH-1:0]  r_rx_data;
  logic                   r_rx_valid, r_overrun, r_frame_err;
  logic                   w_sclk_s, w_mosi_s, w_ss_s;
  logic                   w_sclk_rise, w_ss_fall, w_ss_rise;
  logic                   w_done, w_ferr;

  // Synchronizers plus one edge-detect register. All three pins see the same
  // depth so the synced mosi is the value present at the synced sclk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
      r_sclk_d    <= w_sclk_s;
      r_ss_d      <= w_ss_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_ss_fall   = ~w_ss_s & r_ss_d;
  assign w_ss_rise   = w_ss_s & ~r_ss_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // The sclk edge is applied before the ss edge, so a final bit arriving on the
  // same cycle as ss_rise completes its word and leaves the count at zero.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_bit_cnt;
    w_shift_nx = r_shift;
    w_done     = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall) begin
          w_state_nx = S_SHIFT;
          w_cnt_nx   = '0;
          w_shift_nx = '0;
        end
      end
      S_SHIFT: begin
        if (w_sclk_rise) begin
          // LSB-first shifts in at the top so the first bit ends at bit 0.
          w_shift_nx = LSB_FIRST ? {w_mosi_s, r_shift[DATA_WIDTH-1:1]}
                                 : {r_shift[DATA_WIDTH-2:0], w_mosi_s};
          if (r_bit_cnt == LAST_IDX) begin
            w_done   = 1'b1;
            w_cnt_nx = '0;
          end else begin
            w_cnt_nx = r_bit_cnt + CW'(1);
          end
        end
        if (w_ss_rise) begin
          w_state_nx = S_IDLE;
          w_ferr     = (w_cnt_nx != '0);
          w_cnt_nx   = '0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_bit_cnt   <= w_cnt_nx;
      r_shift     <= w_shift_nx;
      r_frame_err <= w_ferr;
      r_overrun   <= w_done & r_rx_valid & ~rx_ready;
      // Holding register: a new word loads if the slot is empty or is being
      // drained on this very edge; otherwise it is dropped (overrun above).
      if (w_done && (!r_rx_valid || rx_ready)) begin
        r_rx_data  <= w_shift_nx;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
endmodule
